// File: rtl/mem_array_rw_if.sv
// Request/response bus of mem_array_rw: valid/ready request, fixed-latency read response.
// The parity pair (inj_perr, rsp_perr) exists only when MEM_PARITY_EN is defined.
interface mem_array_rw_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
`ifdef MEM_PARITY_EN
  logic              inj_perr;
  logic              rsp_perr;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, inj_perr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, inj_perr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`endif
endinterface

// File: rtl/mem_array_rw.sv
// DEPTH x DATA_W word memory that zero-sweeps itself after reset or clr, with 1-cycle read latency.
// Define MEM_PARITY_EN to store an even-parity bit per word and report rsp_perr on reads.
module mem_array_rw #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          init_busy,
  mem_array_rw_if.slave bus
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef MEM_PARITY_EN
  logic              rsp_perr_q, rsp_perr_d;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic              ready;
  logic              accept;
  logic              in_range;

  always_comb begin
    ready    = (state_q == ST_IDLE) && !clr;
    accept   = bus.req_valid && ready;
    in_range = ({1'b0, bus.req_addr} < DEPTH_L);
    rd_word  = mem[in_range ? bus.req_addr : '0];
`ifdef MEM_PARITY_EN
    wr_word  = {(^bus.req_wdata) ^ bus.inj_perr, bus.req_wdata};
`else
    wr_word  = bus.req_wdata;
`endif
  end

  // Next state, sweep pointer and array write port.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = bus.req_addr;
    mem_wdata = wr_word;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end else if (accept && bus.req_we && in_range) begin
          mem_we = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // Read response; rdata holds its last value between responses.
  always_comb begin
    rsp_valid_d = accept && !bus.req_we;
    rsp_err_d   = rsp_valid_d && !in_range;
    rsp_rdata_d = rsp_rdata_q;
    if (rsp_valid_d) begin
      rsp_rdata_d = in_range ? rd_word[DATA_W-1:0] : '0;
    end
`ifdef MEM_PARITY_EN
    rsp_perr_d  = rsp_valid_d && in_range && (rd_word[DATA_W] != (^rd_word[DATA_W-1:0]));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MEM_PARITY_EN
      rsp_perr_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef MEM_PARITY_EN
      rsp_perr_q  <= rsp_perr_d;
`endif
    end
  end

  // Storage has no reset; the sweep is what clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef MEM_PARITY_EN
  assign bus.rsp_perr  = rsp_perr_q;
`endif
  assign init_busy     = (state_q == ST_INIT);

endmodule
